// File: rtl/cmp_pkg.sv
// Shared encodings and helpers for the chunked sequential magnitude comparator.
package cmp_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ST_W  = 2;

  localparam logic [OP_W-1:0] CMP_GT = 3'd0;
  localparam logic [OP_W-1:0] CMP_GE = 3'd1;
  localparam logic [OP_W-1:0] CMP_LT = 3'd2;
  localparam logic [OP_W-1:0] CMP_LE = 3'd3;
  localparam logic [OP_W-1:0] CMP_EQ = 3'd4;
  localparam logic [OP_W-1:0] CMP_NE = 3'd5;

  localparam logic [ST_W-1:0] IDLE = 2'd0;
  localparam logic [ST_W-1:0] SCAN = 2'd1;
  localparam logic [ST_W-1:0] DONE = 2'd2;

  // Chunk index width; never zero even when there is a single chunk.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

  localparam int unsigned CMP_IDX_W = idx_width(16 / 4);

  // Reserved encodings fall through to 0.
  function automatic logic map_op(input logic [OP_W-1:0] op, input logic gt,
                                  input logic eq, input logic lt);
    logic r;
    r = 1'b0;
    case (op)
      CMP_GT:  r = gt;
      CMP_GE:  r = gt | eq;
      CMP_LT:  r = lt;
      CMP_LE:  r = lt | eq;
      CMP_EQ:  r = eq;
      CMP_NE:  r = ~eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_seq_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module chunk_cmp #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/cmp_seq.sv
// Multi-cycle magnitude comparator: scans operands MSB chunk first and stops
// at the first differing chunk, with valid/ready on both sides.
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             is_signed,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             o,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = idx_width(NCHUNK);

  logic [ST_W-1:0]  state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic             o_q, o_d, gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_gt, c_eq;

  assign a_chunk = xs_q[32'(idx_q) * CHUNK +: CHUNK];
  assign b_chunk = ys_q[32'(idx_q) * CHUNK +: CHUNK];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a  (a_chunk),
    .b  (b_chunk),
    .gt (c_gt),
    .eq (c_eq)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    op_d        = op_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    o_d         = o_q;
    gt_d        = gt_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          xs_d            = x;
          xs_d[WIDTH-1]   = x[WIDTH-1] ^ is_signed;
          ys_d            = y;
          ys_d[WIDTH-1]   = y[WIDTH-1] ^ is_signed;
          op_d            = op;
          idx_d           = IDX_W'(NCHUNK - 1);
          state_d         = SCAN;
        end
      end
      SCAN: begin
        if (!c_eq) begin
          gt_d        = c_gt;
          lt_d        = ~c_gt;
          eq_d        = 1'b0;
          o_d         = map_op(op_q, c_gt, 1'b0, ~c_gt);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          gt_d        = 1'b0;
          lt_d        = 1'b0;
          eq_d        = 1'b1;
          o_d         = map_op(op_q, 1'b0, 1'b1, 1'b0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xs_q        <= '0;
      ys_q        <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      o_q         <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      o_q         <= o_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule
